// File: rtl/rst_pkg.sv
// rtl/rst_pkg.sv - shared types, defaults and helpers for the register status table
//
// Purpose : Defaults for the table geometry, the per-register entry record and a
//           popcount helper used by the busy counter.
// Ports   : none (package).
// Optional: RST_CDB_BYPASS_EN (used by rst_multiport, not by this package).
package rst_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int TAG_W_DEF    = 6;

  // The tag field is sized for the widest tag any build may use. Narrower
  // builds zero-extend into it, so the upper bits are constant zero.
  localparam int TAG_W_MAX    = 16;

  // Widest vector the popcount helper accepts (callers zero-extend).
  localparam int POP_W_MAX    = 256;

  typedef struct packed {
    logic                 busy;
    logic [TAG_W_MAX-1:0] tag;
  } rst_entry_t;

  function automatic int unsigned popcount(input logic [POP_W_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W_MAX; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rst_cdb_match.sv
// rtl/rst_cdb_match.sv - one CDB port's search of the status table for a busy tag
//
// Purpose : Compares one broadcast tag against every busy entry (one-hot) and
//           encodes the matching register index.
// Ports   : i_tab  in  NUM_REGS entries  current table state
//           i_tag  in  TAG_W             broadcast tag
//           o_hit  out 1                 some busy entry holds i_tag
//           o_idx  out AW                index of that entry (0 when no hit)
// Optional: none.
module rst_cdb_match
  import rst_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  rst_entry_t       i_tab [NUM_REGS],
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_hit,
  output logic [AW-1:0]    o_idx
);

  logic [NUM_REGS-1:0] w_onehot;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_onehot[i] = i_tab[i].busy && (i_tab[i].tag == TAG_W_MAX'(i_tag));
    end
  end

  // OR-encoder: tag uniqueness guarantees at most one bit is set, so OR-ing
  // the indices of set bits yields the match index without a priority chain.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_onehot[i]) begin
        o_idx = o_idx | AW'(i);
      end
    end
  end

  assign o_hit = |w_onehot;

endmodule

// File: rtl/rst_multiport.sv
// rtl/rst_multiport.sv - multiport register status table (rename map) for the front end
//
// Purpose : Maps each architectural register to its in-flight producer tag.
//           Dispatch ports rename, CDB ports release and yield register-file
//           write indices, flush clears everything, busy_cnt counts mappings.
// Ports   : clk, rst (async, active-high)
//           disp_we/disp_rd/disp_tag  in   rename requests, higher port = younger
//           rd_addr                   in   source lookups
//           rd_tag/rd_busy            out  lookup results (combinational)
//           cdb_valid/cdb_tag         in   writeback broadcasts
//           wb_we/wb_addr             out  register-file write per CDB port
//           flush                     in   clears all mappings, blocks writes
//           busy_cnt                  out  number of busy registers
// Optional: RST_CDB_BYPASS_EN - lookups of a register whose tag is being
//           broadcast this cycle report not-busy.
module rst_multiport
  import rst_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int TAG_W    = TAG_W_DEF,
  parameter int NUM_DISP = 2,
  parameter int NUM_RD   = 4,
  parameter int NUM_CDB  = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_DISP-1:0]       disp_we,
  input  logic [NUM_DISP*AW-1:0]    disp_rd,
  input  logic [NUM_DISP*TAG_W-1:0] disp_tag,
  input  logic [NUM_RD*AW-1:0]      rd_addr,
  output logic [NUM_RD*TAG_W-1:0]   rd_tag,
  output logic [NUM_RD-1:0]         rd_busy,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  output logic [NUM_CDB-1:0]        wb_we,
  output logic [NUM_CDB*AW-1:0]     wb_addr,
  input  logic                      flush,
  output logic [AW:0]               busy_cnt
);

  rst_entry_t          r_tab     [NUM_REGS];
  rst_entry_t          w_tab_nxt [NUM_REGS];
  logic [AW:0]         r_cnt;

  logic [NUM_CDB-1:0]  w_hit;
  logic [AW-1:0]       w_hit_idx [NUM_CDB];
  logic [NUM_CDB-1:0]  w_wb_we;

  logic [NUM_REGS-1:0] w_busy_cur;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [AW:0]         w_set_n;
  logic [AW:0]         w_clr_n;

  logic [NUM_RD-1:0]   w_rd_byp;
  logic                w_dup_tag;

  // ---------------------------------------------------------------- CDB search
  for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
    rst_cdb_match #(
      .NUM_REGS (NUM_REGS),
      .TAG_W    (TAG_W),
      .AW       (AW)
    ) u_match (
      .i_tab (r_tab),
      .i_tag (cdb_tag[c*TAG_W +: TAG_W]),
      .o_hit (w_hit[c]),
      .o_idx (w_hit_idx[c])
    );
  end

  // A hit still writes the register file when a same-cycle rename of that
  // register overrides the release; only flush suppresses the write.
  always_comb begin
    w_wb_we = '0;
    wb_addr = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      w_wb_we[c] = cdb_valid[c] && w_hit[c] && !flush;
      if (w_wb_we[c]) begin
        wb_addr[c*AW +: AW] = w_hit_idx[c];
      end
    end
  end

  assign wb_we = w_wb_we;

  // ---------------------------------------------------------------- next state
  // Order matters: releases first, then renames in port order so a rename
  // beats a release and the youngest port wins a collision; flush last.
  always_comb begin
    w_tab_nxt = r_tab;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (w_wb_we[c]) begin
        w_tab_nxt[w_hit_idx[c]].busy = 1'b0;
      end
    end
    for (int d = 0; d < NUM_DISP; d++) begin
      if (disp_we[d] && (disp_rd[d*AW +: AW] != '0)) begin
        w_tab_nxt[disp_rd[d*AW +: AW]] = {1'b1, TAG_W_MAX'(disp_tag[d*TAG_W +: TAG_W])};
      end
    end
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        w_tab_nxt[i] = '0;
      end
    end
  end

  // ---------------------------------------------------------------- busy count
  // Incremental update: +entries becoming busy, -entries becoming free. The
  // released set is a subset of the current busy set, so no underflow.
  always_comb begin
    w_busy_cur = '0;
    w_busy_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_busy_cur[i] = r_tab[i].busy;
      w_busy_nxt[i] = w_tab_nxt[i].busy;
    end
  end

  assign w_set   = w_busy_nxt & ~w_busy_cur;
  assign w_clr   = w_busy_cur & ~w_busy_nxt;
  assign w_set_n = (AW+1)'(popcount(POP_W_MAX'(w_set)));
  assign w_clr_n = (AW+1)'(popcount(POP_W_MAX'(w_clr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_tab[i] <= '0;
      end
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_tab[i] <= w_tab_nxt[i];
      end
      r_cnt <= r_cnt + w_set_n - w_clr_n;
    end
  end

  assign busy_cnt = r_cnt;

  // ---------------------------------------------------------------- lookups
`ifdef RST_CDB_BYPASS_EN
  always_comb begin
    w_rd_byp = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      for (int c = 0; c < NUM_CDB; c++) begin
        if (cdb_valid[c] && !flush &&
            (r_tab[rd_addr[r*AW +: AW]].tag == TAG_W_MAX'(cdb_tag[c*TAG_W +: TAG_W]))) begin
          w_rd_byp[r] = 1'b1;
        end
      end
    end
  end
`else
  assign w_rd_byp = '0;
`endif

  // Register 0 is never written, but the explicit guard keeps the zero
  // result independent of table contents.
  always_comb begin
    rd_tag  = '0;
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_addr[r*AW +: AW] != '0) begin
        rd_busy[r]                 = r_tab[rd_addr[r*AW +: AW]].busy && !w_rd_byp[r];
        rd_tag[r*TAG_W +: TAG_W]   = r_tab[rd_addr[r*AW +: AW]].tag[TAG_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- checks
  // Two valid CDB ports carrying the same tag would double-release.
  always_comb begin
    w_dup_tag = 1'b0;
    for (int a = 0; a < NUM_CDB; a++) begin
      for (int b = a + 1; b < NUM_CDB; b++) begin
        if (cdb_valid[a] && cdb_valid[b] &&
            (cdb_tag[a*TAG_W +: TAG_W] == cdb_tag[b*TAG_W +: TAG_W])) begin
          w_dup_tag = 1'b1;
        end
      end
    end
  end

  a_no_dup_cdb_tag : assert property (@(posedge clk) disable iff (rst) !w_dup_tag);

endmodule

// File: tb/tb_rst_multiport.sv
// tb/tb_rst_multiport.sv - table-driven self-checking bench for rst_multiport
module tb_rst_multiport;

`ifdef RST_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  disp_we;
  logic [9:0]  disp_rd;
  logic [11:0] disp_tag;
  logic [19:0] rd_addr;
  logic [23:0] rd_tag;
  logic [3:0]  rd_busy;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [1:0]  wb_we;
  logic [9:0]  wb_addr;
  logic        flush;
  logic [5:0]  busy_cnt;

  rst_multiport dut (
    .clk       (clk),
    .rst       (rst),
    .disp_we   (disp_we),
    .disp_rd   (disp_rd),
    .disp_tag  (disp_tag),
    .rd_addr   (rd_addr),
    .rd_tag    (rd_tag),
    .rd_busy   (rd_busy),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       rs;
    logic [1:0] dwe;
    logic [4:0] drd0, drd1;
    logic [5:0] dtg0, dtg1;
    logic [1:0] cv;
    logic [5:0] ct0, ct1;
    logic       fl;
    logic [4:0] ra0, ra1, ra2, ra3;
    logic [3:0] e_rbusy;
    logic [5:0] e_rtag0;
    logic [1:0] e_wbwe;
    logic [4:0] e_wba0, e_wba1;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec;
  int   n_miss;

  function automatic vec_t mk(string name, int rs, int dwe, int d0, int t0, int d1, int t1,
                              int cv, int c0, int c1, int fl,
                              int a0, int a1, int a2, int a3,
                              int eb, int et, int ew, int ea0, int ea1, int ec);
    vec_t v;
    v.name = name;   v.rs = 1'(rs);
    v.dwe = 2'(dwe); v.drd0 = 5'(d0); v.dtg0 = 6'(t0); v.drd1 = 5'(d1); v.dtg1 = 6'(t1);
    v.cv = 2'(cv);   v.ct0 = 6'(c0);  v.ct1 = 6'(c1);  v.fl = 1'(fl);
    v.ra0 = 5'(a0);  v.ra1 = 5'(a1);  v.ra2 = 5'(a2);  v.ra3 = 5'(a3);
    v.e_rbusy = 4'(eb); v.e_rtag0 = 6'(et); v.e_wbwe = 2'(ew);
    v.e_wba0 = 5'(ea0); v.e_wba1 = 5'(ea1); v.e_cnt = 6'(ec);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst       = v.rs;
    disp_we   = v.dwe;
    disp_rd   = {v.drd1, v.drd0};
    disp_tag  = {v.dtg1, v.dtg0};
    cdb_valid = v.cv;
    cdb_tag   = {v.ct1, v.ct0};
    flush     = v.fl;
    rd_addr   = {v.ra3, v.ra2, v.ra1, v.ra0};
  endtask

  task automatic check(input vec_t e);
    logic ok;
    logic tag_ok;
    // The tag of a non-busy register is only defined for register 0.
    tag_ok = !(e.e_rbusy[0] || e.ra0 == 5'd0) || (rd_tag[5:0] == e.e_rtag0);
    ok = (rd_busy == e.e_rbusy) && tag_ok && (wb_we == e.e_wbwe) &&
         (wb_addr == {e.e_wba1, e.e_wba0}) && (busy_cnt == e.e_cnt);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got rd_busy=%b rd_tag0=%h wb_we=%b wb_addr=%h busy_cnt=%0d, want rd_busy=%b rd_tag0=%h wb_we=%b wb_addr=%h busy_cnt=%0d",
               e.name, rd_busy, rd_tag[5:0], wb_we, wb_addr, busy_cnt,
               e.e_rbusy, e.e_rtag0, e.e_wbwe, {e.e_wba1, e.e_wba0}, e.e_cnt);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1; disp_we = '0; disp_rd = '0; disp_tag = '0;
    cdb_valid = '0; cdb_tag = '0; flush = 1'b0; rd_addr = '0;

    //                name          rs dwe d0  t0    d1  t1    cv c0    c1    fl a0  a1  a2 a3  eb                      et    ew ea0 ea1 ec
    vecs.push_back(mk("reset",      1, 0,  0,  0,    0,  0,    0, 0,    0,    0, 5,  7,  3, 9,  4'b0000,                0,    0, 0,  0,  0));
    vecs.push_back(mk("t1_ren",     0, 1,  5,  'h12, 0,  0,    0, 0,    0,    0, 5,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  0));
    vecs.push_back(mk("t1_look",    0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 5,  0,  0, 0,  4'b0001,                'h12, 0, 0,  0,  1));
    vecs.push_back(mk("t2_coll",    0, 3,  7,  'h03, 7,  'h09, 0, 0,    0,    0, 7,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  1));
    vecs.push_back(mk("t2_look",    0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 7,  5,  0, 0,  4'b0011,                'h09, 0, 0,  0,  2));
    vecs.push_back(mk("t3_ren",     0, 1,  3,  'h04, 0,  0,    0, 0,    0,    0, 3,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  2));
    vecs.push_back(mk("t3_cdb",     0, 0,  0,  0,    0,  0,    1, 'h04, 0,    0, 3,  0,  0, 0,  BYP ? 4'b0000 : 4'b0001, 'h04, 1, 3,  0,  3));
    vecs.push_back(mk("t3_rel",     0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 3,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  2));
    vecs.push_back(mk("t4_ren",     0, 1,  3,  'h04, 0,  0,    0, 0,    0,    0, 0,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  2));
    vecs.push_back(mk("t4_both",    0, 1,  3,  'h0A, 0,  0,    1, 'h04, 0,    0, 3,  0,  0, 0,  BYP ? 4'b0000 : 4'b0001, 'h04, 1, 3,  0,  3));
    vecs.push_back(mk("t4_look",    0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 3,  0,  0, 0,  4'b0001,                'h0A, 0, 0,  0,  3));
    vecs.push_back(mk("t5_ren",     0, 1,  9,  'h11, 0,  0,    0, 0,    0,    0, 9,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  3));
    vecs.push_back(mk("t5_cdb",     0, 0,  0,  0,    0,  0,    2, 0,    'h11, 0, 9,  5,  0, 0,  BYP ? 4'b0010 : 4'b0011, 'h11, 2, 0,  9,  4));
    vecs.push_back(mk("t5_rel",     0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 9,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  3));
    vecs.push_back(mk("dual_cdb",   0, 0,  0,  0,    0,  0,    3, 'h12, 'h09, 0, 5,  7,  3, 0,  BYP ? 4'b0100 : 4'b0111, 'h12, 3, 5,  7,  3));
    vecs.push_back(mk("dual_rel",   0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 5,  7,  3, 0,  4'b0100,                0,    0, 0,  0,  1));
    vecs.push_back(mk("stale_cdb",  0, 0,  0,  0,    0,  0,    1, 'h04, 0,    0, 3,  0,  0, 0,  4'b0001,                'h0A, 0, 0,  0,  1));
    vecs.push_back(mk("x0_ren",     0, 1,  0,  'h3F, 0,  0,    0, 0,    0,    0, 0,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  1));
    vecs.push_back(mk("x0_look",    0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 0,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  1));
    vecs.push_back(mk("fill_a",     0, 3,  10, 'h20, 11, 'h21, 0, 0,    0,    0, 0,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  1));
    vecs.push_back(mk("fill_b",     0, 3,  12, 'h22, 13, 'h23, 0, 0,    0,    0, 0,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  3));
    vecs.push_back(mk("fill_c",     0, 3,  14, 'h24, 15, 'h25, 0, 0,    0,    0, 0,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  5));
    vecs.push_back(mk("fill_d",     0, 3,  16, 'h26, 17, 'h27, 0, 0,    0,    0, 0,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  7));
    vecs.push_back(mk("fill_e",     0, 1,  18, 'h28, 0,  0,    0, 0,    0,    0, 0,  0,  0, 0,  4'b0000,                0,    0, 0,  0,  9));
    vecs.push_back(mk("ten_look",   0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 18, 10, 3, 17, 4'b1111,                'h28, 0, 0,  0,  10));
    vecs.push_back(mk("flush",      0, 1,  20, 'h30, 0,  0,    1, 'h20, 0,    1, 10, 3,  0, 0,  4'b0011,                'h20, 0, 0,  0,  10));
    vecs.push_back(mk("flush_look", 0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 10, 3,  18, 20, 4'b0000,               0,    0, 0,  0,  0));
    vecs.push_back(mk("ren_after",  0, 1,  20, 'h30, 0,  0,    0, 0,    0,    0, 20, 0,  0, 0,  4'b0000,                0,    0, 0,  0,  0));
    vecs.push_back(mk("look_after", 0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 20, 0,  0, 0,  4'b0001,                'h30, 0, 0,  0,  1));
    vecs.push_back(mk("rst_mid",    1, 0,  0,  0,    0,  0,    1, 'h30, 0,    0, 20, 0,  0, 0,  4'b0000,                0,    0, 0,  0,  0));
    vecs.push_back(mk("rst_rel",    0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 20, 0,  0, 0,  4'b0000,                0,    0, 0,  0,  0));
    vecs.push_back(mk("ren_post",   0, 1,  20, 'h31, 0,  0,    0, 0,    0,    0, 20, 0,  0, 0,  4'b0000,                0,    0, 0,  0,  0));
    vecs.push_back(mk("look_post",  0, 0,  0,  0,    0,  0,    0, 0,    0,    0, 20, 0,  0, 0,  4'b0001,                'h31, 0, 0,  0,  1));

    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // later, still before the next rising edge commits the cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      #1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL scoreboard_empty: got no expectation for %s, want one", vecs[i].name);
      end else begin
        check(exp_q.pop_front());
      end
    end

    @(negedge clk);
    disp_we = '0; cdb_valid = '0; flush = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rst_multiport.md
Name: rst_multiport

Overview:
Parametrised Register Status Table for the superscalar front end. It maps each architectural register to the in-flight producer tag, with several dispatch rename ports and several CDB broadcast ports per cycle. On writeback it releases the mapping and produces per-CDB register-file write indices. A flush clears every mapping, and a live count of renamed registers is exported for dispatch stall and debug logic.

Parameters:
NUM_REGS, 32, architectural registers (power of 2)
TAG_W, 6, producer tag width
NUM_DISP, 2, dispatch rename write ports (port index = program order, higher = younger)
NUM_RD, 4, source-lookup read ports
NUM_CDB, 2, CDB broadcast ports
AW, $clog2(NUM_REGS), derived register index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
disp_we  in  NUM_DISP  per-port rename enable
disp_rd  in  NUM_DISP*AW  destination register per port
disp_tag  in  NUM_DISP*TAG_W  new producer tag per port
rd_addr  in  NUM_RD*AW  source register lookup
rd_tag  out  NUM_RD*TAG_W  mapped tag
rd_busy  out  NUM_RD  1 = operand pending on rd_tag
cdb_valid  in  NUM_CDB  broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  broadcast tag
wb_we  out  NUM_CDB  register-file write enable for that CDB port
wb_addr  out  NUM_CDB*AW  register-file write index
flush  in  1  pipeline flush, clears all mappings
busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Storage: per register, a busy bit plus a TAG_W tag. Reset (async) and flush (sync) clear all busy bits and tags. busy_cnt resets to 0.
- Register 0 is never renamed. disp_we for rd=0 is ignored, and the lookup always returns busy=0, tag=0.
- Reads are combinational from current state, with no same-cycle dispatch bypass. Intra-bundle dependencies are resolved by the dispatcher.
- CDB match, per port c: search for the register with busy=1 && tag==cdb_tag[c].
  - At most one match is guaranteed by tag uniqueness.
  - On a match: wb_we[c]=1 and wb_addr[c]=match index.
  - No match (the register was already re-renamed): wb_we[c]=0 and wb_addr[c]=0.
  - wb_* are combinational from current state.
- Release: a matched register clears busy at the next edge, unless any disp_we targets the same register in that cycle. The new mapping wins and wb_we stays 1, because the architectural value is still written.
- Dispatch collision: two dispatch ports with the same rd in one cycle means the highest-index (youngest) port's tag is stored.
- Two CDB ports matching different registers both release. The same tag on two ports is illegal; an assertion flags it.
- Flush has priority over everything in that cycle. No writes land and wb_we is forced to 0.
- busy_cnt tracks registered state: next = popcount(next busy vector). It is computed incrementally (+newly busy, -released) and must never underflow or exceed NUM_REGS-1.
- Latency: rename visible to lookups 1 cycle after disp_we. Release visible 1 cycle after cdb_valid.
- Reset mid-operation: all state clears asynchronously and outputs go to 0 immediately.

Optional Feature:
RST_CDB_BYPASS_EN
- When defined: a read port whose looked-up register is busy with a tag equal to any valid cdb_tag this cycle returns rd_busy=0. This saves one dispatch-to-issue cycle.
- When undefined: lookups see registered state only, and rd_busy stays 1 until the cycle after the broadcast.
- Flush suppresses the bypass in both builds.

Decomposition:
- Package rst_pkg holds:
  - defaults: NUM_REGS_DEF, TAG_W_DEF
  - typedef rst_entry_t {logic busy; logic [TAG_W-1:0] tag;}
  - function popcount
- One sub-module, rst_cdb_match: one instance per CDB port. It takes the entry array and a tag, and outputs hit and index via a one-hot compare and encoder.

Test Plan:
1. Reset, then rename x5→tag 0x12 on port 0. Next cycle lookup x5 gives busy=1, tag=0x12, and busy_cnt=1.
2. Port 0 x7→0x03 and port 1 x7→0x09 in the same cycle: lookup x7 gives tag=0x09 and busy_cnt=1.
3. x3 busy with 0x04, then cdb_valid with tag 0x04: wb_we=1, wb_addr=3. Next cycle x3 busy=0 and busy_cnt decrements.
4. x3 busy with 0x04; in one cycle CDB 0x04 plus dispatch x3→0x0A: wb_we=1, wb_addr=3. x3 remains busy with 0x0A and busy_cnt is unchanged.
5. x9 busy with 0x11, then CDB 0x11 with RST_CDB_BYPASS_EN: same-cycle lookup of x9 gives busy=0. Without the macro it gives busy=1.
6. Ten registers busy, then flush plus a concurrent CDB match: wb_we=0. Next cycle all lookups give busy=0 and busy_cnt=0. Rename of x0 is ignored.
